// File: rtl/rggen_bit_field_clear_initiator.sv
// rtl/rggen_bit_field_clear_initiator.sv - request/response initiator for clear-type rggen bit fields
// Optional post-clear readback cycle: define RGGEN_BIT_FIELD_CLEAR_INITIATOR_READBACK_EN
module rggen_bit_field_clear_initiator #(
    parameter logic [1:0] CLEAR_VALUE = 2'b00,
    parameter int         WIDTH       = 8,
    parameter int         COUNT_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic                   i_req_read,
    input  logic [WIDTH-1:0]       i_req_mask,
    output logic                   o_resp_valid,
    input  logic                   i_resp_ready,
    output logic [WIDTH-1:0]       o_resp_data,
`ifdef RGGEN_BIT_FIELD_CLEAR_INITIATOR_READBACK_EN
    output logic [WIDTH-1:0]       o_resp_post,
`endif
    output logic [COUNT_WIDTH-1:0] o_clear_count,
    output logic                   bit_field_valid,
    output logic [WIDTH-1:0]       bit_field_write_data,
    output logic [WIDTH-1:0]       bit_field_write_mask,
    input  logic [WIDTH-1:0]       bit_field_read_data
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACCESS   = 2'd1;
`ifdef RGGEN_BIT_FIELD_CLEAR_INITIATOR_READBACK_EN
    localparam logic [1:0] READBACK = 2'd2;
`endif
    localparam logic [1:0] RESPONSE = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             req_read_q;
    logic [WIDTH-1:0] req_mask_q;
    logic             clear_hit;
    logic             accept;

    assign accept       = (state == IDLE) && i_req_valid && o_req_ready;
    // A zero mask degenerates into a pure read so the field is never touched.
    assign clear_hit    = !req_read_q && (req_mask_q != '0);
    assign o_resp_valid = (state == RESPONSE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept) state_next = ACCESS;
`ifdef RGGEN_BIT_FIELD_CLEAR_INITIATOR_READBACK_EN
            ACCESS:   state_next = READBACK;
            READBACK: state_next = RESPONSE;
`else
            ACCESS:   state_next = RESPONSE;
`endif
            RESPONSE: if (i_resp_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        bit_field_valid      = 1'b0;
        bit_field_write_data = '0;
        bit_field_write_mask = '0;
        if (state == ACCESS) begin
            bit_field_valid = 1'b1;
            if (clear_hit) begin
                if (CLEAR_VALUE[1]) begin
                    bit_field_write_mask = '1;
                    bit_field_write_data = '0;
                end else if (CLEAR_VALUE[0]) begin
                    bit_field_write_mask = req_mask_q;
                    bit_field_write_data = req_mask_q;
                end else begin
                    bit_field_write_mask = req_mask_q;
                    bit_field_write_data = ~req_mask_q;
                end
            end
        end
`ifdef RGGEN_BIT_FIELD_CLEAR_INITIATOR_READBACK_EN
        if (state == READBACK) begin
            bit_field_valid = 1'b1;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            o_req_ready   <= 1'b0;
            req_read_q    <= 1'b0;
            req_mask_q    <= '0;
            o_resp_data   <= '0;
            o_clear_count <= '0;
        end else begin
            state       <= state_next;
            o_req_ready <= (state_next == IDLE);
            if (accept) begin
                req_read_q <= i_req_read;
                req_mask_q <= i_req_mask;
            end
            if (state == ACCESS) begin
                o_resp_data <= bit_field_read_data;
                if (clear_hit && (o_clear_count != '1)) begin
                    o_clear_count <= o_clear_count + 1'b1;
                end
            end
        end
    end

`ifdef RGGEN_BIT_FIELD_CLEAR_INITIATOR_READBACK_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_resp_post <= '0;
        end else if (state == READBACK) begin
            o_resp_post <= bit_field_read_data;
        end
    end
`endif

endmodule

// File: tb/tb_rggen_bit_field_clear_initiator.sv
// tb/tb_rggen_bit_field_clear_initiator.sv - checks three clear encodings side by side against a field model
module tb_rggen_bit_field_clear_initiator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_read;
    logic [7:0] req_mask;
    logic       resp_ready;

    logic       rdy [3];
    logic       rv  [3];
    logic [7:0] rdata [3];
    logic       bv  [3];
    logic [7:0] wd  [3];
    logic [7:0] wm  [3];
`ifdef RGGEN_BIT_FIELD_CLEAR_INITIATOR_READBACK_EN
    logic [7:0] post [3];
`endif
    logic [1:0]  cnt0;
    logic [15:0] cnt1;
    logic [15:0] cnt2;

    logic [7:0] field    [3];
    logic       load_en;
    logic [7:0] load_val [3];

    int errors = 0;
    int checks = 0;
    int ecount [3];
    int maxc   [3] = '{3, 65535, 65535};

    always #5 clk = ~clk;

    rggen_bit_field_clear_initiator #(.CLEAR_VALUE(2'b01), .WIDTH(8), .COUNT_WIDTH(2)) u_w1c (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(rdy[0]),
        .i_req_read(req_read), .i_req_mask(req_mask), .o_resp_valid(rv[0]),
        .i_resp_ready(resp_ready), .o_resp_data(rdata[0]),
`ifdef RGGEN_BIT_FIELD_CLEAR_INITIATOR_READBACK_EN
        .o_resp_post(post[0]),
`endif
        .o_clear_count(cnt0), .bit_field_valid(bv[0]), .bit_field_write_data(wd[0]),
        .bit_field_write_mask(wm[0]), .bit_field_read_data(field[0])
    );

    rggen_bit_field_clear_initiator #(.CLEAR_VALUE(2'b00), .WIDTH(8), .COUNT_WIDTH(16)) u_w0c (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(rdy[1]),
        .i_req_read(req_read), .i_req_mask(req_mask), .o_resp_valid(rv[1]),
        .i_resp_ready(resp_ready), .o_resp_data(rdata[1]),
`ifdef RGGEN_BIT_FIELD_CLEAR_INITIATOR_READBACK_EN
        .o_resp_post(post[1]),
`endif
        .o_clear_count(cnt1), .bit_field_valid(bv[1]), .bit_field_write_data(wd[1]),
        .bit_field_write_mask(wm[1]), .bit_field_read_data(field[1])
    );

    rggen_bit_field_clear_initiator #(.CLEAR_VALUE(2'b10), .WIDTH(8), .COUNT_WIDTH(16)) u_wc (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(rdy[2]),
        .i_req_read(req_read), .i_req_mask(req_mask), .o_resp_valid(rv[2]),
        .i_resp_ready(resp_ready), .o_resp_data(rdata[2]),
`ifdef RGGEN_BIT_FIELD_CLEAR_INITIATOR_READBACK_EN
        .o_resp_post(post[2]),
`endif
        .o_clear_count(cnt2), .bit_field_valid(bv[2]), .bit_field_write_data(wd[2]),
        .bit_field_write_mask(wm[2]), .bit_field_read_data(field[2])
    );

    function automatic logic [1:0] cv_of(int i);
        return (i == 0) ? 2'b01 : (i == 1) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [15:0] cnt_of(int i);
        return (i == 0) ? {14'b0, cnt0} : (i == 1) ? cnt1 : cnt2;
    endfunction

    // Target field behaviour: W1C, W0C and write-clears-all respectively.
    function automatic logic [7:0] field_write(int i, logic [7:0] f, logic [7:0] m, logic [7:0] d);
        case (cv_of(i))
            2'b01:   return f & ~(m & d);
            2'b00:   return f & ~(m & ~d);
            default: return (m != 8'h00) ? 8'h00 : f;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (load_en) field[i] <= load_val[i];
            else if (bv[i]) field[i] <= field_write(i, field[i], wm[i], wd[i]);
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] v);
        @(negedge clk);
        load_en = 1'b1;
        for (int i = 0; i < 3; i++) load_val[i] = v;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_ready%0d", tag, i), 16'(rdy[i]), 16'h0);
            chk($sformatf("%s_rvalid%0d", tag, i), 16'(rv[i]), 16'h0);
            chk($sformatf("%s_rdata%0d", tag, i), 16'(rdata[i]), 16'h0);
            chk($sformatf("%s_count%0d", tag, i), cnt_of(i), 16'h0);
            chk($sformatf("%s_bfvalid%0d", tag, i), 16'(bv[i]), 16'h0);
`ifdef RGGEN_BIT_FIELD_CLEAR_INITIATOR_READBACK_EN
            chk($sformatf("%s_post%0d", tag, i), 16'(post[i]), 16'h0);
`endif
        end
    endtask

    task automatic wait_ready(input string tag);
        int t = 0;
        while (rdy[0] !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_ready_wait"}, 16'(rdy[0]), 16'h1);
    endtask

    task automatic txn(input logic rd, input logic [7:0] mask, input int stall);
        logic [7:0] pre [3];
        logic [7:0] exp_f, exp_m, exp_d;
        logic clr;
        clr = !rd && (mask != 8'h00);
        wait_ready("txn");
        for (int i = 0; i < 3; i++) pre[i] = field[i];
        req_valid = 1'b1;
        req_read  = rd;
        req_mask  = mask;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_m = 8'h00;
            exp_d = 8'h00;
            if (clr) begin
                case (cv_of(i))
                    2'b01:   begin exp_m = mask;  exp_d = mask;  end
                    2'b00:   begin exp_m = mask;  exp_d = ~mask; end
                    default: begin exp_m = 8'hFF; exp_d = 8'h00; end
                endcase
            end
            chk($sformatf("acc_valid%0d", i), 16'(bv[i]), 16'h1);
            chk($sformatf("acc_wmask%0d", i), 16'(wm[i]), 16'(exp_m));
            chk($sformatf("acc_wdata%0d", i), 16'(wd[i]), 16'(exp_d));
            chk($sformatf("acc_ready%0d", i), 16'(rdy[i]), 16'h0);
            chk($sformatf("acc_rvalid%0d", i), 16'(rv[i]), 16'h0);
        end
`ifdef RGGEN_BIT_FIELD_CLEAR_INITIATOR_READBACK_EN
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rb_valid%0d", i), 16'(bv[i]), 16'h1);
            chk($sformatf("rb_wmask%0d", i), 16'(wm[i]), 16'h0);
            chk($sformatf("rb_rvalid%0d", i), 16'(rv[i]), 16'h0);
        end
`endif
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (clr && ecount[i] < maxc[i]) ecount[i]++;
            if (!clr) exp_f = pre[i];
            else if (cv_of(i) == 2'b10) exp_f = 8'h00;
            else exp_f = pre[i] & ~mask;
            chk($sformatf("rsp_valid%0d", i), 16'(rv[i]), 16'h1);
            chk($sformatf("rsp_data%0d", i), 16'(rdata[i]), 16'(pre[i]));
            chk($sformatf("rsp_bfvalid%0d", i), 16'(bv[i]), 16'h0);
            chk($sformatf("field%0d", i), 16'(field[i]), 16'(exp_f));
            chk($sformatf("count%0d", i), cnt_of(i), 16'(ecount[i]));
`ifdef RGGEN_BIT_FIELD_CLEAR_INITIATOR_READBACK_EN
            chk($sformatf("rsp_post%0d", i), 16'(post[i]), 16'(exp_f));
`endif
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("stall_valid%0d", i), 16'(rv[i]), 16'h1);
                chk($sformatf("stall_data%0d", i), 16'(rdata[i]), 16'(pre[i]));
                chk($sformatf("stall_ready%0d", i), 16'(rdy[i]), 16'h0);
                chk($sformatf("stall_bfvalid%0d", i), 16'(bv[i]), 16'h0);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("done_rvalid%0d", i), 16'(rv[i]), 16'h0);
            chk($sformatf("done_ready%0d", i), 16'(rdy[i]), 16'h1);
        end
    endtask

    initial begin
        logic [7:0] pre [3];
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_read   = 1'b0;
        req_mask   = 8'h00;
        resp_ready = 1'b0;
        load_en    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_val[i] = 8'h00;
            ecount[i]   = 0;
        end
        load(8'hF3);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        chk("ready_before_clock", 16'(rdy[0]), 16'h0);
        @(negedge clk);
        chk("ready_after_clock", 16'(rdy[0]), 16'h1);

        txn(1'b0, 8'h03, 0);
        load(8'h5A);
        txn(1'b0, 8'h01, 0);
        load(8'hA5);
        txn(1'b1, 8'hFF, 0);
        txn(1'b0, 8'h00, 0);
        load(8'hFF);
        txn(1'b0, 8'h01, 5);
        for (int k = 0; k < 4; k++) txn(1'b0, 8'h01 << k, 1);

        load(8'hC3);
        wait_ready("rst");
        for (int i = 0; i < 3; i++) pre[i] = field[i];
        req_valid = 1'b1;
        req_read  = 1'b0;
        req_mask  = 8'h81;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        for (int i = 0; i < 3; i++) ecount[i] = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("midrst_field%0d", i), 16'(field[i]), 16'(pre[i]));
        rst_n = 1'b1;
        @(negedge clk);
        txn(1'b0, 8'h81, 0);

        for (int n = 0; n < 25; n++) begin
            if (n % 4 == 0) load(8'($urandom));
            txn($urandom_range(4) == 0, ($urandom_range(5) == 0) ? 8'h00 : 8'($urandom),
                int'($urandom_range(3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
